systolic_row_feeder: RTL and testbench

Input-side driver for the weight-stationary systolic PE array. It drives the left-edge `in_a`/`enable`/`save` inputs of every array row. In weight-load mode it buffers one full weight tile and shifts it in as a gap-free burst, closing with a broadcast `save`. In stream mode it skews feature vectors diagonally (row r delayed r cycles) so partial sums line up down each column.

---
 rtl/systolic_row_feeder.sv | 158 +++++++++++++++
 tb/tb_systolic_row_feeder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_row_feeder.sv
// Left-edge driver for a weight-stationary systolic array: buffers and bursts
// a weight tile in load mode, and diagonally skews feature beats in stream mode.
//
// state  | meaning
// IDLE   | waiting for a command; outputs reflect the (empty) skew lines
// LOAD_W | accepting COLS weight beats into the tile buffer
// WSHIFT | driving buffered columns COLS-1..0 unskewed, save on column 0
// STREAM | accepting feature beats into the per-row skew lines
// DRAIN  | flushing the skew lines until the last row has emitted
module systolic_row_feeder #(
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int ROWS             = 16,
   parameter int COLS             = 16
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_mode,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [ROWS*INPUT_DATA_WIDTH-1:0] s_data,
   input  logic                             s_last,
   output logic [ROWS*INPUT_DATA_WIDTH-1:0] a_out,
   output logic [ROWS-1:0]                  enable_out,
   output logic                             save_out,
   output logic                             busy,
   output logic                             done
);

   localparam int W    = INPUT_DATA_WIDTH;
   localparam int MAXN = (ROWS > COLS) ? ROWS : COLS;
   localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      WSHIFT,
      STREAM,
      DRAIN
   } state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_m1;
   logic [ROWS*W-1:0]   wbuf [COLS];
   logic                s_fire;
   logic                push_en;
   logic [ROWS*W-1:0]   push_data;
   logic [ROWS*W-1:0]   skew_data;
   logic [ROWS-1:0]     skew_en;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign s_ready   = (state == LOAD_W) || (state == STREAM);
   assign s_fire    = s_valid & s_ready;
   assign cnt_m1    = cnt - 1'b1;

   // Every cycle pushes into the skew lines; idle slots carry (0, 0).
   assign push_en   = (state == STREAM) && s_valid;
   assign push_data = push_en ? s_data : '0;

   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      if (r == 0) begin : g_direct
         assign skew_data[W-1:0] = push_data[W-1:0];
         assign skew_en[0]       = push_en;
      end else begin : g_line
         logic [W-1:0] d_q [r];
         logic [r-1:0] e_q;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int k = 0; k < r; k++) d_q[k] <= '0;
               e_q <= '0;
            end else begin
               d_q[0] <= push_data[r*W +: W];
               e_q[0] <= push_en;
               for (int k = 1; k < r; k++) begin
                  d_q[k] <= d_q[k-1];
                  e_q[k] <= e_q[k-1];
               end
            end
         end

         assign skew_data[r*W +: W] = d_q[r-1];
         assign skew_en[r]          = e_q[r-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= '0;
         a_out      <= '0;
         enable_out <= '0;
         save_out   <= 1'b0;
         done       <= 1'b0;
         for (int c = 0; c < COLS; c++) wbuf[c] <= '0;
      end else begin
         a_out      <= skew_data;
         enable_out <= skew_en;
         save_out   <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state <= cmd_mode ? STREAM : LOAD_W;
                  cnt   <= CW'(COLS - 1);
               end
            end
            LOAD_W: begin
               if (s_fire) begin
                  // Shift-in buffer: after COLS beats, beat k sits in wbuf[k].
                  wbuf[COLS-1] <= s_data;
                  for (int c = 0; c < COLS - 1; c++) wbuf[c] <= wbuf[c+1];
                  if (cnt == '0) begin
                     // Last beat goes straight out as the first shifted column.
                     state      <= WSHIFT;
                     cnt        <= CW'(COLS - 1);
                     a_out      <= s_data;
                     enable_out <= '0;
                     save_out   <= (COLS == 1);
                  end else begin
                     cnt <= cnt_m1;
                  end
               end
            end
            WSHIFT: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else begin
                  a_out      <= wbuf[cnt_m1];
                  enable_out <= '0;
                  save_out   <= (cnt == CW'(1));
                  cnt        <= cnt_m1;
               end
            end
            STREAM: begin
               if (s_fire && s_last) begin
                  state <= DRAIN;
                  cnt   <= CW'(ROWS - 1);
               end
            end
            DRAIN: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt_m1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Bench for systolic_row_feeder: table-driven load/stream vectors with a
// cycle-stamped scoreboard for the skewed stream outputs.
module tb_systolic_row_feeder;

   localparam int W    = 8;
   localparam int ROWS = 4;
   localparam int COLS = 4;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_mode = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [ROWS*W-1:0] s_data = '0;
   logic              s_last = 1'b0;
   logic [ROWS*W-1:0] a_out;
   logic [ROWS-1:0]   enable_out;
   logic              save_out;
   logic              busy;
   logic              done;

   systolic_row_feeder #(
      .INPUT_DATA_WIDTH(W),
      .ROWS(ROWS),
      .COLS(COLS)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .s_last(s_last),
      .a_out(a_out),
      .enable_out(enable_out),
      .save_out(save_out),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   logic mon_on = 1'b0;

   typedef struct {
      logic       vld;
      logic       last;
      logic [7:0] base;
   } svec_t;

   typedef struct {
      logic [31:0] beat;
      logic        bubble_after;
      logic [31:0] exp_a;
      logic        exp_save;
   } wvec_t;

   typedef struct {
      int         cyc;
      int         row;
      logic [7:0] d;
   } exp_t;

   svec_t svec [9];
   wvec_t wvec [COLS];
   exp_t  sbq [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle();
      chk("idle_a_out", a_out, 0);
      chk("idle_enable", enable_out, 0);
      chk("idle_save", save_out, 0);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_s_ready", s_ready, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
   endtask

   task automatic issue_cmd(input logic mode);
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      chk("cmd_ready_idle", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic stream_beats(input int s, input int e, output int tl);
      tl = cyc;
      for (int i = s; i <= e; i++) begin
         s_valid = svec[i].vld;
         s_last  = svec[i].last;
         s_data  = 32'hA5A5_A5A5;
         if (svec[i].vld) begin
            for (int r = 0; r < ROWS; r++) begin
               s_data[r*W +: W] = svec[i].base + 8'(r);
               sbq.push_back('{cyc + 1 + r, r, svec[i].base + 8'(r)});
            end
            chk("s_ready_stream", s_ready, 1);
         end
         if (svec[i].last) tl = cyc;
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
   endtask

   task automatic wait_done(input int tl);
      bit found = 1'b0;
      for (int k = 0; k < ROWS + 8 && !found; k++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            chk("done_cycle", cyc, tl + ROWS + 1);
         end else begin
            chk("cmd_stall", cmd_ready, 0);
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles of last beat", ROWS + 8);
      end
   endtask

   // Stream monitor: every enabled lane must match a scheduled entry, every
   // other lane must be (en=0, data=0).
   logic [ROWS-1:0]   m_en;
   logic [ROWS*W-1:0] m_d;
   always @(negedge clk) begin
      if (mon_on) begin
         m_en = '0;
         m_d  = '0;
         for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
               m_en[sbq[i].row]        = 1'b1;
               m_d[sbq[i].row*W +: W]  = sbq[i].d;
               sbq.delete(i);
            end
         end
         chk("stream_en", enable_out, m_en);
         chk("stream_data", a_out, m_d);
         chk("stream_save", save_out, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          tl;
      logic [31:0] tb_beat;
      logic [31:0] tb_exp;

      for (int j = 0; j < COLS; j++) begin
         for (int r = 0; r < ROWS; r++) begin
            tb_beat[r*W +: W] = 8'(16 * j + r + 1);
            tb_exp[r*W +: W]  = 8'(16 * (COLS - 1 - j) + r + 1);
         end
         wvec[j] = '{tb_beat, (j == 1), tb_exp, (j == COLS - 1)};
      end
      svec[0] = '{1'b1, 1'b0, 8'h00};
      svec[1] = '{1'b1, 1'b0, 8'h0A};
      svec[2] = '{1'b1, 1'b1, 8'h14};
      svec[3] = '{1'b1, 1'b0, 8'h40};
      svec[4] = '{1'b0, 1'b0, 8'h00};
      svec[5] = '{1'b1, 1'b1, 8'h60};
      svec[6] = '{1'b1, 1'b1, 8'h70};
      svec[7] = '{1'b1, 1'b0, 8'h80};
      svec[8] = '{1'b1, 1'b1, 8'h90};

      // Reset, then idle
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (5) step();
      @(negedge clk);
      check_idle();

      // s_valid in IDLE is not accepted and produces nothing
      mon_on = 1'b1;
      step();
      s_valid = 1'b1;
      s_data  = 32'h5A5A_5A5A;
      repeat (3) begin
         step();
         @(negedge clk);
         chk("idle_s_valid_ready", s_ready, 0);
      end
      s_valid = 1'b0;
      s_data  = '0;
      mon_on  = 1'b0;

      // Weight load with a bubble after beat 1
      step();
      issue_cmd(1'b0);
      for (int j = 0; j < COLS; j++) begin
         s_valid = 1'b1;
         s_data  = wvec[j].beat;
         chk("s_ready_load", s_ready, 1);
         step();
         if (wvec[j].bubble_after) begin
            s_valid = 1'b0;
            s_data  = 32'hDEAD_BEEF;
            step();
         end
      end
      s_valid = 1'b0;
      s_data  = '0;
      for (int j = 0; j < COLS; j++) begin
         @(negedge clk);
         chk("wshift_a", a_out, wvec[j].exp_a);
         chk("wshift_save", save_out, wvec[j].exp_save);
         chk("wshift_en", enable_out, 0);
         chk("wshift_done", done, 0);
         step();
      end
      @(negedge clk);
      chk("load_done", done, 1);
      chk("load_done_cmd_ready", cmd_ready, 1);
      chk("load_done_a_out", a_out, 0);
      chk("load_done_save", save_out, 0);
      step();
      @(negedge clk);
      chk("load_done_pulse", done, 0);

      // Contiguous 3-beat stream
      mon_on = 1'b1;
      step();
      issue_cmd(1'b1);
      stream_beats(0, 2, tl);
      wait_done(tl);
      chk("sb_empty_a", sbq.size(), 0);

      // Stream with a bubble between beats
      step();
      issue_cmd(1'b1);
      stream_beats(3, 5, tl);
      wait_done(tl);
      chk("sb_empty_b", sbq.size(), 0);

      // Single-beat stream
      step();
      issue_cmd(1'b1);
      stream_beats(6, 6, tl);
      wait_done(tl);
      chk("sb_empty_c", sbq.size(), 0);

      // Command held during a stream is taken on the done cycle
      step();
      issue_cmd(1'b1);
      cmd_valid = 1'b1;
      cmd_mode  = 1'b1;
      stream_beats(3, 5, tl);
      wait_done(tl);
      chk("held_cmd_ready_on_done", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
      chk("held_cmd_busy", busy, 1);
      chk("held_cmd_s_ready", s_ready, 1);
      stream_beats(6, 6, tl);
      wait_done(tl);
      chk("sb_empty_d", sbq.size(), 0);

      // Reset during DRAIN
      step();
      issue_cmd(1'b1);
      stream_beats(7, 8, tl);
      @(posedge clk);
      #3;
      mon_on = 1'b0;
      sbq.delete();
      rstn = 1'b0;
      #1;
      check_idle();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_reset_no_done", done, 0);
         chk("post_reset_enable", enable_out, 0);
         step();
      end
      mon_on = 1'b1;
      issue_cmd(1'b1);
      stream_beats(6, 6, tl);
      wait_done(tl);
      chk("sb_empty_e", sbq.size(), 0);
      step();
      mon_on = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
